// File: rtl/led_pwm_pkg.sv
// Shared constants and the channel-index width helper for the LED PWM bank.
package led_pwm_pkg;

  localparam int PWM_WIDTH_DEF    = 8;
  localparam int PWM_CHANNELS_DEF = 8;
  localparam int PWM_PRESCALE_DEF = 195;

  // Index width for n items; never below 1 so a single item still gets a port bit.
  function automatic int cw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable prescaler: one-cycle tick every PRESCALE clocks while enabled.
// Used instead of a derived slow clock so everything stays in the clk domain.
module pwm_prescaler
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic clk,
  input  logic resn,
  input  logic enable,
  output logic tick
);

  localparam int PW = cw_of(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // Tick on the last count of each period; PRESCALE = 1 ticks every enabled cycle.
  assign tick = enable && (pcnt_q == LAST);

  // Next count: held at 0 while halted, wraps to 0 after the tick.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!enable || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel PWM bank with frame-aligned (shadow-buffered) duty updates.
//
// Write handshake: duty_ready is combinational from duty_chan only (high when
// that channel has no pending update, always high for out-of-range channels);
// a write is accepted on any cycle where duty_valid && duty_ready, at most one
// per cycle. Out-of-range writes are accepted and dropped.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int  CHANNELS = PWM_CHANNELS_DEF,
  parameter int  WIDTH    = PWM_WIDTH_DEF,
  parameter int  PRESCALE = PWM_PRESCALE_DEF,
  localparam int CW       = cw_of(CHANNELS)
) (
  input  logic                clk,
  input  logic                resn,
  input  logic                enable,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic [CW-1:0]       duty_chan,
  input  logic [WIDTH-1:0]    duty_value,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_tick
);

  logic                            tick;
  logic                            wrap;
  logic                            commit;
  logic                            accept;
  logic [WIDTH-1:0]                fcnt_q, fcnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  active_q, active_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic [CHANNELS-1:0]             pending_q, pending_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            frame_tick_q;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .resn   (resn),
    .enable (enable),
    .tick   (tick)
  );

  // A wrap is the tick that takes the frame counter from all-ones back to 0.
  assign wrap   = tick && (fcnt_q == '1);
  // Updates land at frame boundaries, or immediately while halted.
  assign commit = wrap || !enable;
  assign accept = duty_valid && duty_ready;

  // Ready is the selected channel's free slot; unmatched indices stay ready.
  always_comb begin
    duty_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (duty_chan == CW'(i)) begin
        duty_ready = !pending_q[i];
      end
    end
  end

  // Next frame count, duty arrays and compare result.
  always_comb begin
    fcnt_d    = fcnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pwm_d     = '0;
    if (!enable) begin
      fcnt_d = '0;
    end else if (tick) begin
      fcnt_d = fcnt_q + 1'b1;
    end
    // Commit before accept: a write landing on the wrap cycle waits a frame.
    for (int i = 0; i < CHANNELS; i++) begin
      if (commit && pending_q[i]) begin
        active_d[i]  = shadow_q[i];
        pending_d[i] = 1'b0;
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (accept && (duty_chan == CW'(i))) begin
        shadow_d[i]  = duty_value;
        pending_d[i] = 1'b1;
      end
    end
    // Compare against the upcoming count so each high run starts on the
    // frame_tick cycle.
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = enable && (fcnt_d < active_d[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      fcnt_q       <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pwm_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      fcnt_q       <= fcnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= wrap;
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank: two instances (4 ch / prescale 2 and 3 ch / prescale 1),
// a frame-position model checked every cycle, and literal frame-level checks.
module tb_led_pwm_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resn;
  logic [1:0]      en;
  logic [1:0]      valid;
  logic [1:0][1:0] chan;
  logic [1:0][3:0] value;
  wire  [1:0]      ready;
  wire  [1:0]      ft;
  wire  [3:0]      pwm0;
  wire  [2:0]      pwm1;

  led_pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(2)) u_dut0 (
    .clk(clk), .resn(resn), .enable(en[0]), .duty_valid(valid[0]),
    .duty_ready(ready[0]), .duty_chan(chan[0]), .duty_value(value[0]),
    .pwm_out(pwm0), .frame_tick(ft[0])
  );

  led_pwm_bank #(.CHANNELS(3), .WIDTH(4), .PRESCALE(1)) u_dut1 (
    .clk(clk), .resn(resn), .enable(en[1]), .duty_valid(valid[1]),
    .duty_ready(ready[1]), .duty_chan(chan[1]), .duty_value(value[1]),
    .pwm_out(pwm1), .frame_tick(ft[1])
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Position within the frame is a single cycle index 0..PRESCALE*16-1;
  // the frame count is that index divided by PRESCALE.
  int        phase_m [2];
  int        active_m[2][4];
  int        shadow_m[2][4];
  bit        pending_m[2][4];
  bit [3:0]  exp_pwm [2];
  bit        exp_ft  [2];

  function automatic int nch(input int d);  return (d == 0) ? 4 : 3; endfunction
  function automatic int pre(input int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int flen(input int d); return pre(d) * 16;      endfunction

  function automatic bit exp_ready(input int d, input int ch);
    if (ch >= nch(d)) return 1'b1;
    return !pending_m[d][ch];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      phase_m[d] = 0;
      exp_pwm[d] = '0;
      exp_ft[d]  = 1'b0;
      for (int c = 0; c < 4; c++) begin
        active_m[d][c]  = 0;
        shadow_m[d][c]  = 0;
        pending_m[d][c] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int d);
    bit e, acc, wrap;
    int ch;
    e    = en[d];
    ch   = int'(chan[d]);
    acc  = valid[d] && exp_ready(d, ch);
    wrap = e && (phase_m[d] == flen(d) - 1);
    if (!e || wrap) begin
      for (int c = 0; c < nch(d); c++) begin
        if (pending_m[d][c]) begin
          active_m[d][c]  = shadow_m[d][c];
          pending_m[d][c] = 1'b0;
        end
      end
    end
    if (acc && ch < nch(d)) begin
      shadow_m[d][ch]  = int'(value[d]);
      pending_m[d][ch] = 1'b1;
    end
    phase_m[d] = e ? (phase_m[d] + 1) % flen(d) : 0;
    for (int c = 0; c < 4; c++) begin
      exp_pwm[d][c] = e && (c < nch(d)) && ((phase_m[d] / pre(d)) < active_m[d][c]);
    end
    exp_ft[d] = wrap;
  endtask

  always @(posedge clk or negedge resn) begin
    if (!resn) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("cycle_d0", int'({ready[0], ft[0], pwm0}),
            int'({exp_ready(0, int'(chan[0])), exp_ft[0], exp_pwm[0]}));
      check("cycle_d1", int'({ready[1], ft[1], 1'b0, pwm1}),
            int'({exp_ready(1, int'(chan[1])), exp_ft[1], exp_pwm[1]}));
    end
  end

  // ---------------- high-time per frame monitor ----------------
  int cur_hi [2][4];
  int last_hi[2][4];

  always @(negedge clk) begin : hi_mon
    logic [3:0] p;
    for (int d = 0; d < 2; d++) begin
      p = (d == 0) ? pwm0 : {1'b0, pwm1};
      if (ft[d] === 1'b1) begin
        for (int c = 0; c < 4; c++) begin
          last_hi[d][c] = cur_hi[d][c];
          cur_hi[d][c]  = 0;
        end
      end
      for (int c = 0; c < 4; c++) cur_hi[d][c] += (p[c] === 1'b1) ? 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_tick(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ft[d] !== 1'b1 && n < 200);
    check($sformatf("tick_seen_d%0d", d), int'(n < 200), 1);
    #1;
  endtask

  task automatic wr(input int d, input int ch, input int val, output int stall);
    valid[d] = 1'b1;
    chan[d]  = 2'(ch);
    value[d] = 4'(val);
    #1;
    stall = 0;
    while (ready[d] !== 1'b1 && stall < 200) begin
      @(posedge clk); #1;
      stall++;
    end
    check("wr_accepted", int'(stall < 200), 1);
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, st;
    resn  = 1'b1;
    en    = '0;
    valid = '0;
    chan  = '0;
    value = '0;
    model_reset();
    #2 resn = 1'b0;
    #1 started = 1'b1;
    repeat (3) @(posedge clk);
    #1 resn = 1'b1;
    en = 2'b11;

    // First wrap lands on the 32nd edge after release.
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ft[0] !== 1'b1 && n < 100);
    check("first_tick_after_release", n, 32);

    // Duty shape.
    wr(0, 0, 4, st); wr(0, 1, 0, st); wr(0, 2, 15, st); wr(0, 3, 8, st);
    wait_tick(0); wait_tick(0);
    check("hi_ch0_duty4",  last_hi[0][0], 8);
    check("hi_ch1_duty0",  last_hi[0][1], 0);
    check("hi_ch2_duty15", last_hi[0][2], 30);
    check("hi_ch3_duty8",  last_hi[0][3], 16);

    // Frame-aligned commit.
    repeat ($urandom_range(5, 15)) @(negedge clk);
    #1;
    wr(0, 0, 12, st);
    check("ready_low_after_accept", int'(ready[0]), 0);
    wait_tick(0);
    check("ready_back_after_wrap", int'(ready[0]), 1);
    check("hi_ch0_old_frame", last_hi[0][0], 8);
    wait_tick(0);
    check("hi_ch0_new_frame", last_hi[0][0], 24);

    // Backpressure: second write stalls until the first commits.
    wr(0, 1, 3, st);
    wr(0, 1, 5, st);
    check("stall_until_commit", int'(st > 0), 1);
    wait_tick(0);
    check("hi_ch1_first", last_hi[0][1], 6);
    wait_tick(0);
    check("hi_ch1_second", last_hi[0][1], 10);

    // Write accepted on the wrap cycle commits one frame later.
    repeat (31) @(negedge clk);
    #1;
    valid[0] = 1'b1; chan[0] = 2'd3; value[0] = 4'd2;
    #1;
    check("ready_on_wrap_cycle", int'(ready[0]), 1);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    check("collision_on_wrap", int'(ft[0]), 1);
    wait_tick(0); wait_tick(0);
    check("hi_ch3_not_yet", last_hi[0][3], 16);
    wait_tick(0);
    check("hi_ch3_next_frame", last_hi[0][3], 4);

    // Halt: outputs low, writes commit the next cycle, restart from 0.
    en[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("halt_pwm_zero", int'(pwm0), 0);
    check("halt_no_tick", int'(ft[0]), 0);
    #1;
    wr(0, 2, 6, st);
    check("halt_pending", int'(ready[0]), 0);
    @(posedge clk); #1;
    check("halt_commit_next_cycle", int'(ready[0]), 1);
    @(negedge clk); #1;
    en[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ft[0] !== 1'b1 && n < 100);
    check("restart_tick", n, 32);
    wait_tick(0); wait_tick(0);
    check("hi_ch2_after_restart", last_hi[0][2], 12);

    // Three-channel, PRESCALE = 1 instance.
    wr(1, 0, 5, st);
    wait_tick(1); wait_tick(1);
    check("d1_hi_ch0", last_hi[1][0], 5);
    n = 0;
    do begin @(negedge clk); n++; end while (ft[1] !== 1'b1 && n < 100);
    check("d1_frame_len", n, 16);
    #1;
    valid[1] = 1'b1; chan[1] = 2'd3; value[1] = 4'd9;
    #1;
    check("oor_ready", int'(ready[1]), 1);
    @(posedge clk); #1;
    valid[1] = 1'b0;
    wait_tick(1); wait_tick(1);
    check("oor_ch0", last_hi[1][0], 5);
    check("oor_ch1", last_hi[1][1], 0);
    check("oor_ch2", last_hi[1][2], 0);

    // Reset mid-frame with an update in flight.
    wait_tick(0);
    wr(0, 1, 9, st);
    repeat (3) @(negedge clk);
    #1;
    check("ready_low_before_reset", int'(ready[0]), 0);
    resn = 1'b0;
    #1;
    check("reset_pwm", int'(pwm0), 0);
    check("reset_tick", int'(ft[0]), 0);
    check("reset_ready", int'(ready[0]), 1);
    repeat (2) @(posedge clk);
    #1 resn = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ft[0] !== 1'b1 && n < 100);
    check("tick_after_midframe_reset", n, 32);
    wait_tick(0); wait_tick(0);
    check("pending_lost_ch1", last_hi[0][1], 0);
    check("reset_cleared_ch0", last_hi[0][0], 0);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 39) == 0) en[d] = ~en[d];
        valid[d] = ($urandom_range(0, 2) == 0);
        chan[d]  = 2'($urandom_range(0, 3));
        value[d] = 4'($urandom_range(0, 15));
      end
    end
    valid = '0;
    en    = 2'b11;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
